// File: rtl/pi1_memtest_pkg.sv
// Shared PI1 definitions for the memory self-test block: bus op encodings and clog2.
package pi1_memtest_pkg;

    typedef enum logic [1:0] {
        PINOOP = 2'd0,
        PIWROP = 2'd1,
        PIRDOP = 2'd2,
        PIRWOP = 2'd3
    } pi1_op_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        if (value > 1) begin
            v = value - 1;
            while (v > 0) begin
                result = result + 1;
                v = v >> 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/pi1_memtest_if.sv
// PI1 bus bundle between one initiator and one responder.
interface pi1_memtest_if
    import pi1_memtest_pkg::*;
#(
    parameter int unsigned ARCHBITSZ = 32
);
    localparam int unsigned ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ / 8);

    logic [1:0]             op;
    logic [ADDRBITSZ-1:0]   addr;
    logic [ARCHBITSZ-1:0]   wdata;
    logic [ARCHBITSZ-1:0]   rdata;
    logic [ARCHBITSZ/8-1:0] sel;
    logic                   rdy;

    modport master (
        output op,
        output addr,
        output wdata,
        output sel,
        input  rdata,
        input  rdy
    );

    modport slave (
        input  op,
        input  addr,
        input  wdata,
        input  sel,
        output rdata,
        output rdy
    );

endinterface

// File: rtl/pi1_memtest_lfsr32_galois.sv
// 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, with seed load and advance enable.
module pi1_memtest_lfsr32_galois (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        advance,
    output logic [31:0] state
);

    // Right-shifting Galois form: taps 32,22,2,1 map to bits 31,21,1,0.
    localparam logic [31:0] Poly = 32'h8020_0003;

    logic [31:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = seed;
        end else if (advance) begin
            state_d = {1'b0, state_q[31:1]} ^ (state_q[0] ? Poly : 32'h0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= 32'h1;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/pi1_memtest.sv
// PI1 initiator running an LFSR write/read-back memory self-test over a word range.
// Define PI1_MEMTEST_INVPASS_EN to add a second write/read pass using the inverted pattern.
module pi1_memtest
    import pi1_memtest_pkg::*;
#(
    parameter  int unsigned ARCHBITSZ = 32,
    parameter  int unsigned CNTBITSZ  = 16,
    localparam int unsigned ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ / 8)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [ADDRBITSZ-1:0] base_i,
    input  logic [CNTBITSZ-1:0]  count_i,
    input  logic [ARCHBITSZ-1:0] seed_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [CNTBITSZ-1:0]  errcnt_o,
    output logic [ADDRBITSZ-1:0] erraddr_o,
    pi1_memtest_if.master        pi1
);

`ifdef PI1_MEMTEST_INVPASS_EN
    typedef enum logic [3:0] {
        StIdle, StWrReq, StWrRsp, StRdReq, StRdRsp,
        StIwrReq, StIwrRsp, StIrdReq, StIrdRsp, StFin
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StWrReq, StWrRsp, StRdReq, StRdRsp, StFin
    } state_e;
`endif

    state_e               state_q, state_d;
    logic [ADDRBITSZ-1:0] cur_q, cur_d;
    logic [ADDRBITSZ-1:0] base_q, base_d;
    logic [CNTBITSZ-1:0]  count_q, count_d;
    logic [CNTBITSZ-1:0]  remain_q, remain_d;
    logic [31:0]          seed_q, seed_d;
    logic [CNTBITSZ-1:0]  errcnt_q, errcnt_d;
    logic [ADDRBITSZ-1:0] erraddr_q, erraddr_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;

    logic        lfsr_load, lfsr_adv;
    logic [31:0] lfsr_seed, lfsr_state;
    logic [31:0] seed_eff;
    logic        is_wr_req, is_rd_req, inv_phase, last;
    logic        step, reload, check;

    logic [ARCHBITSZ-1:0] base_word, pattern;

    pi1_memtest_lfsr32_galois u_lfsr (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .load    (lfsr_load),
        .seed    (lfsr_seed),
        .advance (lfsr_adv),
        .state   (lfsr_state)
    );

    if (ARCHBITSZ == 64) begin : g_word64
        assign base_word = {~lfsr_state, lfsr_state};
    end else begin : g_word32
        assign base_word = lfsr_state;
    end

    // An all-zero seed would lock the LFSR at zero.
    assign seed_eff = (seed_i[31:0] == 32'h0) ? 32'h1 : seed_i[31:0];
    assign last     = (remain_q == CNTBITSZ'(1));

`ifdef PI1_MEMTEST_INVPASS_EN
    assign is_wr_req = (state_q == StWrReq) || (state_q == StIwrReq);
    assign is_rd_req = (state_q == StRdReq) || (state_q == StIrdReq);
    assign inv_phase = (state_q == StIwrReq) || (state_q == StIwrRsp) ||
                       (state_q == StIrdReq) || (state_q == StIrdRsp);
`else
    assign is_wr_req = (state_q == StWrReq);
    assign is_rd_req = (state_q == StRdReq);
    assign inv_phase = 1'b0;
`endif

    assign pattern = inv_phase ? ~base_word : base_word;

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        base_d    = base_q;
        count_d   = count_q;
        remain_d  = remain_q;
        seed_d    = seed_q;
        errcnt_d  = errcnt_q;
        erraddr_d = erraddr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        lfsr_seed = seed_q;
        step      = 1'b0;
        reload    = 1'b0;
        check     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    base_d    = base_i;
                    cur_d     = base_i;
                    count_d   = count_i;
                    remain_d  = count_i;
                    seed_d    = seed_eff;
                    lfsr_seed = seed_eff;
                    lfsr_load = 1'b1;
                    errcnt_d  = '0;
                    erraddr_d = '0;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = (count_i == '0) ? StFin : StWrReq;
                end
            end
            StWrReq: if (pi1.rdy) state_d = StWrRsp;
            StWrRsp: begin
                if (pi1.rdy) begin
                    if (last) begin
                        reload  = 1'b1;
                        state_d = StRdReq;
                    end else begin
                        step    = 1'b1;
                        state_d = StWrReq;
                    end
                end
            end
            StRdReq: if (pi1.rdy) state_d = StRdRsp;
            StRdRsp: begin
                if (pi1.rdy) begin
                    check = 1'b1;
                    if (last) begin
`ifdef PI1_MEMTEST_INVPASS_EN
                        reload  = 1'b1;
                        state_d = StIwrReq;
`else
                        state_d = StFin;
`endif
                    end else begin
                        step    = 1'b1;
                        state_d = StRdReq;
                    end
                end
            end
`ifdef PI1_MEMTEST_INVPASS_EN
            StIwrReq: if (pi1.rdy) state_d = StIwrRsp;
            StIwrRsp: begin
                if (pi1.rdy) begin
                    if (last) begin
                        reload  = 1'b1;
                        state_d = StIrdReq;
                    end else begin
                        step    = 1'b1;
                        state_d = StIwrReq;
                    end
                end
            end
            StIrdReq: if (pi1.rdy) state_d = StIrdRsp;
            StIrdRsp: begin
                if (pi1.rdy) begin
                    check = 1'b1;
                    if (last) begin
                        state_d = StFin;
                    end else begin
                        step    = 1'b1;
                        state_d = StIrdReq;
                    end
                end
            end
`endif
            StFin: begin
                done_d  = 1'b1;
                pass_d  = (errcnt_q == '0);
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (reload) begin
            cur_d     = base_q;
            remain_d  = count_q;
            lfsr_seed = seed_q;
            lfsr_load = 1'b1;
        end else if (step) begin
            cur_d    = cur_q + ADDRBITSZ'(1);
            remain_d = remain_q - CNTBITSZ'(1);
            lfsr_adv = 1'b1;
        end

        if (check && (pi1.rdata != pattern)) begin
            if (errcnt_q != '1) begin
                errcnt_d = errcnt_q + CNTBITSZ'(1);
            end
            if (errcnt_q == '0) begin
                erraddr_d = cur_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= StIdle;
            cur_q     <= '0;
            base_q    <= '0;
            count_q   <= '0;
            remain_q  <= '0;
            seed_q    <= 32'h1;
            errcnt_q  <= '0;
            erraddr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            base_q    <= base_d;
            count_q   <= count_d;
            remain_q  <= remain_d;
            seed_q    <= seed_d;
            errcnt_q  <= errcnt_d;
            erraddr_q <= erraddr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    assign pi1.op    = is_wr_req ? PIWROP : (is_rd_req ? PIRDOP : PINOOP);
    assign pi1.addr  = cur_q;
    assign pi1.wdata = is_wr_req ? pattern : '0;
    assign pi1.sel   = '1;

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign pass_o    = pass_q;
    assign errcnt_o  = errcnt_q;
    assign erraddr_o = erraddr_q;

endmodule

// File: tb/tb_pi1_memtest.sv
// Directed bench for pi1_memtest with a small smem-style responder (stall and stuck-bit modes).
module tb_pi1_memtest;
    import pi1_memtest_pkg::*;

    localparam int unsigned ARCHBITSZ = 32;
    localparam int unsigned CNTBITSZ  = 16;
    localparam int unsigned ADDRBITSZ = 30;
`ifdef PI1_MEMTEST_INVPASS_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    logic                 clk = 1'b0;
    logic                 rst_i = 1'b0;
    logic                 start_i = 1'b0;
    logic [ADDRBITSZ-1:0] base_i = '0;
    logic [CNTBITSZ-1:0]  count_i = '0;
    logic [ARCHBITSZ-1:0] seed_i = '0;
    logic                 busy_o, done_o, pass_o;
    logic [CNTBITSZ-1:0]  errcnt_o;
    logic [ADDRBITSZ-1:0] erraddr_o;

    int checks = 0;
    int errors = 0;

    pi1_memtest_if #(.ARCHBITSZ(ARCHBITSZ)) bus ();

    pi1_memtest #(.ARCHBITSZ(ARCHBITSZ), .CNTBITSZ(CNTBITSZ)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .base_i    (base_i),
        .count_i   (count_i),
        .seed_i    (seed_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .pass_o    (pass_o),
        .errcnt_o  (errcnt_o),
        .erraddr_o (erraddr_o),
        .pi1       (bus)
    );

    always #5 clk = ~clk;

    // Responder model
    logic        stall_en = 1'b0;
    logic        stuck_en = 1'b0;
    logic        pending = 1'b0;
    int          wcnt = 0;
    logic [31:0] rd_word = '0;
    logic [31:0] mem [16];
    logic [1:0]  log_op [1024];
    logic [29:0] log_addr [1024];
    logic [31:0] log_data [1024];
    int          log_n = 0;
    int          unstable = 0;
    int          bad_sel = 0;
    logic        prev_wait = 1'b0;
    logic [1:0]  prev_op = '0;
    logic [29:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    assign bus.rdy   = stall_en ? (wcnt == 3) : 1'b1;
    assign bus.rdata = rd_word;

    always @(posedge clk) begin
        if (!rst_i) begin
            pending   <= 1'b0;
            wcnt      <= 0;
            prev_wait <= 1'b0;
        end else begin
            if (prev_wait && (bus.op !== prev_op || bus.addr !== prev_addr ||
                              bus.wdata !== prev_data)) begin
                unstable <= unstable + 1;
            end
            prev_wait <= (bus.op != PINOOP) && !bus.rdy;
            prev_op   <= bus.op;
            prev_addr <= bus.addr;
            prev_data <= bus.wdata;
            if (bus.op != PINOOP && bus.rdy && !pending) begin
                pending               <= 1'b1;
                log_op[log_n % 1024]   <= bus.op;
                log_addr[log_n % 1024] <= bus.addr;
                log_data[log_n % 1024] <= bus.wdata;
                log_n                 <= log_n + 1;
                if (bus.sel !== 4'hF) bad_sel <= bad_sel + 1;
                if (bus.op == PIWROP) begin
                    mem[bus.addr[3:0]] <= (stuck_en && bus.addr == 30'h405) ?
                                          (bus.wdata | 32'h1) : bus.wdata;
                end else begin
                    rd_word <= mem[bus.addr[3:0]];
                end
            end else if (pending && bus.rdy) begin
                pending <= 1'b0;
            end
            if ((bus.op != PINOOP) || pending) begin
                if (bus.rdy) wcnt <= 0;
                else if (wcnt < 3) wcnt <= wcnt + 1;
            end
        end
    end

    task automatic run_test(input logic [29:0] b, input logic [15:0] c, input logic [31:0] s,
                            input int poke_at, output int cycles, output logic busy_seen);
        cycles    = 0;
        busy_seen = 1'b0;
        @(negedge clk);
        base_i  = b;
        count_i = c;
        seed_i  = s;
        start_i = 1'b1;
        while (cycles < 2000) begin
            @(negedge clk);
            cycles++;
            start_i = 1'b0;
            if (cycles == 1) busy_seen = busy_o;
            if (done_o) break;
            if (cycles == poke_at) begin
                start_i = 1'b1;
                count_i = 16'd1;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || pass_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got busy=%b done=%b pass=%b want 0 0 0",
                     busy_o, done_o, pass_o);
        end
        checks++;
        if (errcnt_o !== '0 || erraddr_o !== '0) begin
            errors++;
            $display("FAIL reset_err got errcnt=%h erraddr=%h want 0 0", errcnt_o, erraddr_o);
        end
        checks++;
        if (bus.op !== PINOOP || bus.addr !== '0 || bus.wdata !== '0 || bus.sel !== 4'hF) begin
            errors++;
            $display("FAIL reset_bus got op=%h addr=%h data=%h sel=%h want 0 0 0 f",
                     bus.op, bus.addr, bus.wdata, bus.sel);
        end
        rst_i = 1'b1;
    endtask

    task automatic test_basic();
        int   cyc;
        logic b1;
        int   n0;
        int   sel0;
        n0   = log_n;
        sel0 = bad_sel;
        run_test(30'h400, 16'd16, 32'h1, 10, cyc, b1);
        checks++;
        if (cyc !== 64 * PASSES + 2) begin
            errors++;
            $display("FAIL basic_latency got %0d want %0d", cyc, 64 * PASSES + 2);
        end
        checks++;
        if (b1 !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy got %b want 1", b1);
        end
        checks++;
        if (pass_o !== 1'b1 || errcnt_o !== 16'd0) begin
            errors++;
            $display("FAIL basic_pass got pass=%b errcnt=%0d want 1 0", pass_o, errcnt_o);
        end
        checks++;
        if (log_n - n0 !== 32 * PASSES) begin
            errors++;
            $display("FAIL basic_accesses got %0d want %0d", log_n - n0, 32 * PASSES);
        end
        checks++;
        if (log_op[n0] !== PIWROP || log_addr[n0] !== 30'h400 || log_op[n0 + 15] !== PIWROP ||
            log_addr[n0 + 15] !== 30'h40F) begin
            errors++;
            $display("FAIL basic_wr_range got %h@%h %h@%h want 1@400 1@40f", log_op[n0],
                     log_addr[n0], log_op[n0 + 15], log_addr[n0 + 15]);
        end
        checks++;
        if (log_op[n0 + 16] !== PIRDOP || log_addr[n0 + 16] !== 30'h400 ||
            log_op[n0 + 31] !== PIRDOP || log_addr[n0 + 31] !== 30'h40F) begin
            errors++;
            $display("FAIL basic_rd_range got %h@%h %h@%h want 2@400 2@40f", log_op[n0 + 16],
                     log_addr[n0 + 16], log_op[n0 + 31], log_addr[n0 + 31]);
        end
        checks++;
        if (log_data[n0] !== 32'h1 || log_data[n0 + 1] !== 32'h8020_0003 ||
            log_data[n0 + 2] !== 32'hC030_0002 || log_data[n0 + 5] !== 32'hD836_0002) begin
            errors++;
            $display("FAIL basic_pattern got %h %h %h %h want 1 80200003 c0300002 d8360002",
                     log_data[n0], log_data[n0 + 1], log_data[n0 + 2], log_data[n0 + 5]);
        end
        checks++;
        if (bad_sel !== sel0) begin
            errors++;
            $display("FAIL basic_sel got %0d bad byte-enable accesses want 0", bad_sel - sel0);
        end
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse got done=%b busy=%b want 0 0", done_o, busy_o);
        end
    endtask

    task automatic test_stuck();
        int   cyc;
        logic b1;
        stuck_en = 1'b1;
        run_test(30'h400, 16'd16, 32'h1, 0, cyc, b1);
        stuck_en = 1'b0;
        checks++;
        if (errcnt_o !== 16'd1 || erraddr_o !== 30'h405 || pass_o !== 1'b0) begin
            errors++;
            $display("FAIL stuck_result got errcnt=%0d erraddr=%h pass=%b want 1 405 0",
                     errcnt_o, erraddr_o, pass_o);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (errcnt_o !== 16'd1 || erraddr_o !== 30'h405 || pass_o !== 1'b0) begin
            errors++;
            $display("FAIL stuck_hold got errcnt=%0d erraddr=%h pass=%b want 1 405 0",
                     errcnt_o, erraddr_o, pass_o);
        end
    endtask

    task automatic test_count_zero();
        int   cyc;
        logic b1;
        int   n0;
        n0 = log_n;
        run_test(30'h400, 16'd0, 32'h5, 0, cyc, b1);
        checks++;
        if (cyc !== 2 || pass_o !== 1'b1 || errcnt_o !== 16'd0) begin
            errors++;
            $display("FAIL count0 got latency=%0d pass=%b errcnt=%0d want 2 1 0",
                     cyc, pass_o, errcnt_o);
        end
        checks++;
        if (log_n !== n0) begin
            errors++;
            $display("FAIL count0_noop got %0d accesses want 0", log_n - n0);
        end
    endtask

    task automatic test_stall();
        int   cyc;
        logic b1;
        int   u0;
        u0       = unstable;
        stall_en = 1'b1;
        run_test(30'h400, 16'd16, 32'h1, 0, cyc, b1);
        stall_en = 1'b0;
        checks++;
        if (cyc !== 256 * PASSES + 2) begin
            errors++;
            $display("FAIL stall_latency got %0d want %0d", cyc, 256 * PASSES + 2);
        end
        checks++;
        if (unstable !== u0) begin
            errors++;
            $display("FAIL stall_stable got %0d changes while stalled want 0", unstable - u0);
        end
        checks++;
        if (pass_o !== 1'b1 || errcnt_o !== 16'd0) begin
            errors++;
            $display("FAIL stall_pass got pass=%b errcnt=%0d want 1 0", pass_o, errcnt_o);
        end
    endtask

    task automatic test_wrap();
        int   cyc;
        logic b1;
        int   n0;
        n0 = log_n;
        run_test(30'h3FFF_FFFF, 16'd2, 32'h0, 0, cyc, b1);
        checks++;
        if (cyc !== 8 * PASSES + 2 || pass_o !== 1'b1) begin
            errors++;
            $display("FAIL wrap_result got latency=%0d pass=%b want %0d 1", cyc, pass_o,
                     8 * PASSES + 2);
        end
        checks++;
        if (log_addr[n0] !== 30'h3FFF_FFFF || log_addr[n0 + 1] !== 30'h0 ||
            log_addr[n0 + 2] !== 30'h3FFF_FFFF || log_addr[n0 + 3] !== 30'h0 ||
            log_op[n0 + 2] !== PIRDOP) begin
            errors++;
            $display("FAIL wrap_addr got %h %h %h %h want 3fffffff 0 3fffffff 0", log_addr[n0],
                     log_addr[n0 + 1], log_addr[n0 + 2], log_addr[n0 + 3]);
        end
        checks++;
        if (log_data[n0] !== 32'h1 || log_data[n0 + 1] !== 32'h8020_0003) begin
            errors++;
            $display("FAIL wrap_seed0 got %h %h want 1 80200003", log_data[n0], log_data[n0 + 1]);
        end
    endtask

    task automatic test_reset_mid();
        int   cyc;
        int   n0;
        logic b1;
        logic hit;
        n0       = log_n;
        hit      = 1'b0;
        stuck_en = 1'b1;
        @(negedge clk);
        base_i  = 30'h400;
        count_i = 16'd16;
        seed_i  = 32'h1;
        start_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start_i = 1'b0;
            // Read of 0x406 just accepted: the DUT now waits in the read-response state.
            if (log_n - n0 >= 23) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (hit !== 1'b1 || errcnt_o !== 16'd1) begin
            errors++;
            $display("FAIL midrst_pre got reached=%b errcnt=%0d want 1 1", hit, errcnt_o);
        end
        rst_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.op !== PINOOP || busy_o !== 1'b0 || errcnt_o !== '0 || erraddr_o !== '0 ||
            pass_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state got op=%h busy=%b errcnt=%0d erraddr=%h pass=%b want 0 0 0 0 0",
                     bus.op, busy_o, errcnt_o, erraddr_o, pass_o);
        end
        rst_i    = 1'b1;
        stuck_en = 1'b0;
        run_test(30'h400, 16'd4, 32'h7, 0, cyc, b1);
        checks++;
        if (cyc !== 16 * PASSES + 2 || pass_o !== 1'b1 || errcnt_o !== 16'd0) begin
            errors++;
            $display("FAIL midrst_rerun got latency=%0d pass=%b errcnt=%0d want %0d 1 0",
                     cyc, pass_o, errcnt_o, 16 * PASSES + 2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stuck();
        test_count_zero();
        test_stall();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pi1_memtest.md
Name: pi1_memtest

Overview:
- PI1 bus initiator (master) that runs a built-in memory self-test over a word range of any PI1 responder.
- It writes an LFSR pattern across the range, then reads the range back and compares each word against the regenerated pattern.
- It plugs onto a master slot of the PI1 interconnect, next to the CPU.
- Used in simulation and bring-up to qualify smem and other memory slaves without CPU firmware.

Parameters:
- ARCHBITSZ, 32, data width in bits; legal values 32 or 64.
- ADDRBITSZ, ARCHBITSZ-clog2(ARCHBITSZ/8), word-address width (localparam, derived).
- CNTBITSZ, 16, width of the word-count input and the error counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-low reset, sampled on the rising edge of clk_i.
- start_i  in  1  pulse; starts a test when idle.
- base_i  in  ADDRBITSZ  first word address.
- count_i  in  CNTBITSZ  number of words to test.
- seed_i  in  ARCHBITSZ  LFSR seed.
- busy_o  out  1  test in progress.
- done_o  out  1  one-cycle pulse at test end.
- pass_o  out  1  errcnt_o==0 at last completion.
- errcnt_o  out  CNTBITSZ  mismatches; saturating.
- erraddr_o  out  ADDRBITSZ  word address of the first mismatch.
- pi1_op_o  out  2  PI1 op: 0 NOOP, 1 WR, 2 RD, 3 RW (RW never issued).
- pi1_addr_o  out  ADDRBITSZ  word address.
- pi1_data_o  out  ARCHBITSZ  write data.
- pi1_data_i  in  ARCHBITSZ  read data.
- pi1_sel_o  out  ARCHBITSZ/8  byte enables; always all-ones.
- pi1_rdy_i  in  1  responder ready.

Behaviour:
- Reset (rst_i==0 at an edge) is valid mid-transaction:
  - pi1_op_o goes to NOOP in the next cycle and the FSM goes to IDLE.
  - busy_o=0, done_o=0, pass_o=0, errcnt_o=0, erraddr_o=0.
  - pi1_addr_o=0, pi1_data_o=0, pi1_sel_o=all-ones.
- PI1 handshake:
  - A request is accepted on an edge where pi1_op_o!=NOOP and pi1_rdy_i==1.
  - Op, addr, data and sel stay stable until accepted; op is NOOP in the cycle after acceptance.
  - The response is the first later edge with pi1_rdy_i==1. For RD, pi1_data_i is sampled at that edge.
  - At most one transaction is outstanding.
- FSM states: IDLE, WRREQ, WRRSP, RDREQ, RDRSP, FIN.
  - IDLE: on start_i, latch base_i, count_i and seed_i. A zero seed is replaced by 1. Clear errcnt_o, erraddr_o and pass_o, set busy_o, go to WRREQ. If count_i==0, go to FIN instead.
  - WRREQ: drive WR, addr=cur, data=lfsr; on acceptance go to WRRSP.
  - WRRSP: on response, advance lfsr, cur+1 and remaining-1. When remaining reaches 0, reload cur=base and lfsr=seed and go to RDREQ; otherwise go to WRREQ.
  - RDREQ / RDRSP mirror the write states. On the RDRSP response, compare pi1_data_i with lfsr.
    - On mismatch, errcnt_o+1, saturating at all-ones.
    - On the first mismatch only, erraddr_o=cur.
    - After the last word go to FIN.
  - FIN: done_o=1 for exactly one cycle, pass_o=(errcnt_o==0), busy_o=0, go to IDLE.
- LFSR: Galois, polynomial x^32+x^22+x^2+x+1 on the low 32 bits. For ARCHBITSZ=64 the word is {~lfsr, lfsr}. Advances once per completed write or read.
- cur increments modulo 2^ADDRBITSZ; wrap from all-ones to 0 is legal and not an error.
- start_i while busy_o=1 is ignored.
- errcnt_o, erraddr_o and pass_o hold their values after FIN until the next start.
- Throughput with an always-ready responder: 2 cycles per word per phase. Total for N words = 4N + 2 cycles from start to the done pulse.

Optional Feature:
- Macro: PI1_MEMTEST_INVPASS_EN.
- Defined:
  - After the read phase, run a second write phase and a second read phase using ~pattern. This adds states IWRREQ/IWRRSP/IRDREQ/IRDRSP; the LFSR reloads from the seed before each.
  - Mismatches from both read phases accumulate in errcnt_o.
  - Latency becomes 8N + 2 cycles.
- Undefined: single pattern pass only; those states are not generated.

Decomposition:
- Shared package (pi1 include): PI1 op encodings PINOOP/PIWROP/PIRDOP/PIRWOP and the clog2 function.
- Local constants: FSM state encodings and the LFSR polynomial.
- One natural sub-module: lfsr32_galois (seed load, advance enable, 32-bit state out), reusable by other BIST blocks.

Test Plan:
- Always-ready smem model: base=0x400, count=16, seed=0x1 -> 16 WR then 16 RD at 0x400..0x40F; done_o at cycle 66 after start; pass_o=1; errcnt_o=0.
- Responder with a stuck bit 0 at word 0x405 -> errcnt_o=1, erraddr_o=0x405, pass_o=0.
- pi1_rdy_i low for 3 cycles during each request and each response -> op/addr/data stable while stalled; same pass result; latency grows by 6 cycles per word per phase.
- count=0 -> no PI1 op issued; done_o 2 cycles after start_i; pass_o=1.
- Reset asserted during RDRSP -> next cycle: op=NOOP, busy_o=0, errcnt_o=0; a new start after reset runs cleanly.
- base=all-ones, count=2 -> accesses at all-ones then 0; pass_o=1. Seed=0 behaves identically to seed=1.
